// File: rtl/mem_port_arbiter_if.sv
// Bundle of IFU, LSU and memory handshake signals around the shared memory port.
// Handshake: a request transfers on a cycle where valid && ready; resp_valid is a one-cycle pulse with no back-pressure.
interface mem_port_arbiter_if;
  logic        ifu_req_valid;
  logic [31:0] ifu_req_addr;
  logic        ifu_req_ready;
  logic        ifu_resp_valid;
  logic [31:0] ifu_resp_data;

  logic        lsu_req_valid;
  logic [31:0] lsu_req_addr;
  logic        lsu_req_wen;
  logic [31:0] lsu_req_wdata;
  logic [3:0]  lsu_req_wmask;
  logic        lsu_req_ready;
  logic        lsu_resp_valid;
  logic [31:0] lsu_resp_data;

  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_wen;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wmask;
  logic        mem_req_ready;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;

  // master: the arbiter itself; slave: the IFU, LSU and memory around it.
  modport master (
    input  ifu_req_valid, ifu_req_addr,
    output ifu_req_ready, ifu_resp_valid, ifu_resp_data,
    input  lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_wmask,
    output lsu_req_ready, lsu_resp_valid, lsu_resp_data,
    output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
    input  mem_req_ready, mem_resp_valid, mem_resp_data
  );

  modport slave (
    output ifu_req_valid, ifu_req_addr,
    input  ifu_req_ready, ifu_resp_valid, ifu_resp_data,
    output lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_wmask,
    input  lsu_req_ready, lsu_resp_valid, lsu_resp_data,
    input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
    output mem_req_ready, mem_resp_valid, mem_resp_data
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter sharing one memory port between IFU (reads) and LSU (reads/writes).
// LSU has priority; an IFU starvation guard and a response timeout watchdog bound latency.
module mem_port_arbiter #(
  parameter int MAX_IFU_WAIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic                clk,
  input  logic                rstn,
  mem_port_arbiter_if.master  bus,
  output logic                busy,
  output logic                owner,
  output logic                timeout_err,
  output logic                spurious_err,
  output logic [1:0]          dbg_state,
  output logic [7:0]          dbg_wait_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam logic [7:0]  MAX_W   = 8'(MAX_IFU_WAIT);
  localparam logic [16:0] TMO_LIM = 17'(TIMEOUT);

  state_t      state;
  logic [7:0]  wait_cnt;
  logic [15:0] tmo_cnt;

  logic ifu_force;
  logic grant_lsu;
  logic grant_ifu;
  logic accept;
  logic tmo_hit;

  assign ifu_force = bus.ifu_req_valid && (wait_cnt == MAX_W);
  assign grant_lsu = bus.lsu_req_valid && !ifu_force;
  assign grant_ifu = bus.ifu_req_valid && !grant_lsu;
  assign accept    = (state == IDLE) && (grant_lsu || grant_ifu);

  // Gated by rstn so no ready is visible while the block is held in reset.
  assign bus.lsu_req_ready = rstn && (state == IDLE) && grant_lsu;
  assign bus.ifu_req_ready = rstn && (state == IDLE) && grant_ifu;

  // tmo_cnt is 0 in the first ISSUE cycle; aborting here puts the error pulse TIMEOUT cycles after accept.
  assign tmo_hit = ({1'b0, tmo_cnt} + 17'd2) >= TMO_LIM;

  assign busy         = (state != IDLE);
  assign dbg_state    = state;
  assign dbg_wait_cnt = wait_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state              <= IDLE;
      wait_cnt           <= 8'd0;
      tmo_cnt            <= 16'd0;
      owner              <= 1'b0;
      timeout_err        <= 1'b0;
      spurious_err       <= 1'b0;
      bus.mem_req_valid  <= 1'b0;
      bus.mem_req_addr   <= 32'd0;
      bus.mem_req_wen    <= 1'b0;
      bus.mem_req_wdata  <= 32'd0;
      bus.mem_req_wmask  <= 4'd0;
      bus.ifu_resp_valid <= 1'b0;
      bus.ifu_resp_data  <= 32'd0;
      bus.lsu_resp_valid <= 1'b0;
      bus.lsu_resp_data  <= 32'd0;
    end else begin
      bus.ifu_resp_valid <= 1'b0;
      bus.lsu_resp_valid <= 1'b0;

      if (bus.mem_resp_valid && (state != WAIT)) begin
        spurious_err <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (grant_ifu) begin
            wait_cnt <= 8'd0;
          end else if (grant_lsu && bus.ifu_req_valid && (wait_cnt < MAX_W)) begin
            wait_cnt <= wait_cnt + 8'd1;
          end
          if (accept) begin
            owner             <= grant_lsu;
            bus.mem_req_valid <= 1'b1;
            bus.mem_req_addr  <= grant_lsu ? bus.lsu_req_addr : bus.ifu_req_addr;
            bus.mem_req_wen   <= grant_lsu && bus.lsu_req_wen;
            bus.mem_req_wdata <= (grant_lsu && bus.lsu_req_wen) ? bus.lsu_req_wdata : 32'd0;
            bus.mem_req_wmask <= (grant_lsu && bus.lsu_req_wen) ? bus.lsu_req_wmask : 4'd0;
            tmo_cnt           <= 16'd0;
            state             <= ISSUE;
          end
        end

        ISSUE: begin
          tmo_cnt <= tmo_cnt + 16'd1;
          if (tmo_hit) begin
            bus.mem_req_valid <= 1'b0;
            timeout_err       <= 1'b1;
            if (owner) begin
              bus.lsu_resp_valid <= 1'b1;
              bus.lsu_resp_data  <= 32'hDEADBEEF;
            end else begin
              bus.ifu_resp_valid <= 1'b1;
              bus.ifu_resp_data  <= 32'hDEADBEEF;
            end
            state <= IDLE;
          end else if (bus.mem_req_ready) begin
            bus.mem_req_valid <= 1'b0;
            state             <= WAIT;
          end
        end

        WAIT: begin
          tmo_cnt <= tmo_cnt + 16'd1;
          // A real response on the timeout cycle takes precedence over the abort.
          if (bus.mem_resp_valid) begin
            if (owner) begin
              bus.lsu_resp_valid <= 1'b1;
              bus.lsu_resp_data  <= bus.mem_req_wen ? 32'd0 : bus.mem_resp_data;
            end else begin
              bus.ifu_resp_valid <= 1'b1;
              bus.ifu_resp_data  <= bus.mem_resp_data;
            end
            state <= IDLE;
          end else if (tmo_hit) begin
            timeout_err <= 1'b1;
            if (owner) begin
              bus.lsu_resp_valid <= 1'b1;
              bus.lsu_resp_data  <= 32'hDEADBEEF;
            end else begin
              bus.ifu_resp_valid <= 1'b1;
              bus.ifu_resp_data  <= 32'hDEADBEEF;
            end
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: inputs driven and outputs sampled at the falling edge.
module tb_mem_port_arbiter;

  logic       clk;
  logic       rstn;
  logic       busy;
  logic       owner;
  logic       timeout_err;
  logic       spurious_err;
  logic [1:0] dbg_state;
  logic [7:0] dbg_wait_cnt;

  int n_cmp;
  int n_bad;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(
    .MAX_IFU_WAIT (4),
    .TIMEOUT      (10)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .bus          (bus),
    .busy         (busy),
    .owner        (owner),
    .timeout_err  (timeout_err),
    .spurious_err (spurious_err),
    .dbg_state    (dbg_state),
    .dbg_wait_cnt (dbg_wait_cnt)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish want finish before 100us");
    $fatal(1, "bench watchdog expired");
  end

  // driver tasks
  task automatic idle_inputs;
    bus.ifu_req_valid  = 1'b0;
    bus.ifu_req_addr   = 32'd0;
    bus.lsu_req_valid  = 1'b0;
    bus.lsu_req_addr   = 32'd0;
    bus.lsu_req_wen    = 1'b0;
    bus.lsu_req_wdata  = 32'd0;
    bus.lsu_req_wmask  = 4'd0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data  = 32'd0;
  endtask

  task automatic next_cycle;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    idle_inputs();
    next_cycle();
    #1;
    n_cmp++;
    if ({busy, owner, timeout_err, spurious_err, bus.mem_req_valid, bus.ifu_resp_valid,
         bus.lsu_resp_valid, bus.ifu_req_ready, bus.lsu_req_ready} !== 9'd0) begin
      n_bad++;
      $display("FAIL reset_flags: got %b want 0", {busy, owner, timeout_err, spurious_err,
               bus.mem_req_valid, bus.ifu_resp_valid, bus.lsu_resp_valid, bus.ifu_req_ready, bus.lsu_req_ready});
    end
    n_cmp++;
    if ({dbg_state, dbg_wait_cnt, bus.mem_req_addr, bus.mem_req_wdata, bus.mem_req_wmask} !== 78'd0) begin
      n_bad++;
      $display("FAIL reset_regs: got state=%0d wait=%0d addr=%h want all 0", dbg_state, dbg_wait_cnt, bus.mem_req_addr);
    end
    next_cycle();
    rstn = 1'b1;
  endtask

  task automatic test_ifu_read;
    next_cycle();
    bus.ifu_req_valid = 1'b1;
    bus.ifu_req_addr  = 32'h8000_0000;
    bus.mem_req_ready = 1'b1;
    #1;
    n_cmp++;
    if ({bus.ifu_req_ready, bus.lsu_req_ready} !== 2'b10) begin
      n_bad++;
      $display("FAIL ifu_ready_c0: got %b want 10", {bus.ifu_req_ready, bus.lsu_req_ready});
    end
    next_cycle();
    bus.ifu_req_valid = 1'b0;
    #1;
    n_cmp++;
    if ({bus.mem_req_valid, bus.mem_req_addr, bus.mem_req_wen, bus.mem_req_wmask, busy, owner} !==
        {1'b1, 32'h8000_0000, 1'b0, 4'd0, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL ifu_issue_c1: got v=%b addr=%h wen=%b busy=%b owner=%b want v=1 addr=80000000 wen=0 busy=1 owner=0",
               bus.mem_req_valid, bus.mem_req_addr, bus.mem_req_wen, busy, owner);
    end
    next_cycle();
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = 32'h0000_0413;
    #1;
    n_cmp++;
    if ({bus.mem_req_valid, dbg_state} !== {1'b0, 2'd2}) begin
      n_bad++;
      $display("FAIL ifu_wait_c2: got v=%b state=%0d want v=0 state=2", bus.mem_req_valid, dbg_state);
    end
    next_cycle();
    bus.mem_resp_valid = 1'b0;
    #1;
    n_cmp++;
    if ({bus.ifu_resp_valid, bus.ifu_resp_data, bus.lsu_resp_valid, busy} !== {1'b1, 32'h0000_0413, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL ifu_resp_c3: got v=%b data=%h lsu_v=%b busy=%b want v=1 data=00000413 lsu_v=0 busy=0",
               bus.ifu_resp_valid, bus.ifu_resp_data, bus.lsu_resp_valid, busy);
    end
    next_cycle();
    #1;
    n_cmp++;
    if ({bus.ifu_resp_valid, bus.ifu_resp_data} !== {1'b0, 32'h0000_0413}) begin
      n_bad++;
      $display("FAIL ifu_resp_c4: got v=%b data=%h want v=0 data=00000413", bus.ifu_resp_valid, bus.ifu_resp_data);
    end
  endtask

  task automatic test_starvation;
    int   g;
    int   exp_w [6];
    logic [5:0] exp_lsu;
    exp_lsu = 6'b101111;
    exp_w   = '{0, 1, 2, 3, 4, 0};
    g = 0;
    bus.lsu_req_wen   = 1'b0;
    bus.mem_req_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      next_cycle();
      bus.ifu_req_valid  = (g < 6);
      bus.lsu_req_valid  = (g < 6);
      bus.ifu_req_addr   = 32'h0000_1000 + 32'(c * 4);
      bus.lsu_req_addr   = 32'h0000_2000 + 32'(c * 4);
      bus.mem_resp_valid = (dbg_state == 2'd2);
      bus.mem_resp_data  = 32'h0000_0100 + 32'(c);
      #1;
      if ((bus.ifu_req_ready || bus.lsu_req_ready) && g < 6) begin
        n_cmp++;
        if ({bus.ifu_req_ready, bus.lsu_req_ready, dbg_wait_cnt} !== {!exp_lsu[g], exp_lsu[g], 8'(exp_w[g])}) begin
          n_bad++;
          $display("FAIL starve_grant%0d: got ifu=%b lsu=%b wait=%0d want ifu=%b lsu=%b wait=%0d", g,
                   bus.ifu_req_ready, bus.lsu_req_ready, dbg_wait_cnt, !exp_lsu[g], exp_lsu[g], exp_w[g]);
        end
        g++;
      end
    end
    n_cmp++;
    if (g !== 6) begin
      n_bad++;
      $display("FAIL starve_count: got %0d grants want 6", g);
    end
    idle_inputs();
  endtask

  task automatic test_store_stall;
    next_cycle();
    bus.lsu_req_valid = 1'b1;
    bus.lsu_req_addr  = 32'h8000_0100;
    bus.lsu_req_wen   = 1'b1;
    bus.lsu_req_wdata = 32'hA5A5_A5A5;
    bus.lsu_req_wmask = 4'b0011;
    #1;
    n_cmp++;
    if ({bus.lsu_req_ready, bus.ifu_req_ready} !== 2'b10) begin
      n_bad++;
      $display("FAIL store_ready: got lsu=%b ifu=%b want lsu=1 ifu=0", bus.lsu_req_ready, bus.ifu_req_ready);
    end
    for (int c = 1; c <= 4; c++) begin
      next_cycle();
      bus.lsu_req_valid = 1'b0;
      bus.lsu_req_addr  = 32'h1234_5678;
      bus.lsu_req_wdata = 32'h0;
      bus.lsu_req_wmask = 4'b1100;
      bus.mem_req_ready = (c == 4);
      #1;
      n_cmp++;
      if ({bus.mem_req_valid, bus.mem_req_addr, bus.mem_req_wen, bus.mem_req_wdata, bus.mem_req_wmask, owner} !==
          {1'b1, 32'h8000_0100, 1'b1, 32'hA5A5_A5A5, 4'b0011, 1'b1}) begin
        n_bad++;
        $display("FAIL store_hold_c%0d: got v=%b addr=%h wen=%b wdata=%h wmask=%b owner=%b want 1 80000100 1 a5a5a5a5 0011 1",
                 c, bus.mem_req_valid, bus.mem_req_addr, bus.mem_req_wen, bus.mem_req_wdata, bus.mem_req_wmask, owner);
      end
    end
    next_cycle();
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = 32'h1234_5678;
    next_cycle();
    bus.mem_resp_valid = 1'b0;
    #1;
    n_cmp++;
    if ({bus.lsu_resp_valid, bus.lsu_resp_data, bus.ifu_resp_valid, timeout_err} !== {1'b1, 32'd0, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL store_resp: got v=%b data=%h ifu_v=%b tmo=%b want v=1 data=0 ifu_v=0 tmo=0",
               bus.lsu_resp_valid, bus.lsu_resp_data, bus.ifu_resp_valid, timeout_err);
    end
    // IFU data last written by the starvation run's IFU response (memory data 0x10e)
    n_cmp++;
    if (bus.ifu_resp_data !== 32'h0000_010E) begin
      n_bad++;
      $display("FAIL ifu_data_hold: got %h want 0000010e", bus.ifu_resp_data);
    end
    idle_inputs();
  endtask

  task automatic test_coincide;
    logic early;
    early = 1'b0;
    next_cycle();
    bus.ifu_req_valid = 1'b1;
    bus.ifu_req_addr  = 32'h0000_0200;
    for (int c = 1; c <= 9; c++) begin
      next_cycle();
      bus.ifu_req_valid  = 1'b0;
      bus.mem_req_ready  = (c == 1);
      bus.mem_resp_valid = (c == 9);
      bus.mem_resp_data  = 32'hCAFE_F00D;
      #1;
      if (bus.ifu_resp_valid || bus.lsu_resp_valid) early = 1'b1;
    end
    n_cmp++;
    if (early !== 1'b0) begin
      n_bad++;
      $display("FAIL coincide_early: got early pulse=1 want 0");
    end
    next_cycle();
    bus.mem_resp_valid = 1'b0;
    #1;
    n_cmp++;
    if ({bus.ifu_resp_valid, bus.ifu_resp_data, timeout_err, spurious_err, busy} !==
        {1'b1, 32'hCAFE_F00D, 1'b0, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL coincide_resp: got v=%b data=%h tmo=%b spur=%b busy=%b want 1 cafef00d 0 0 0",
               bus.ifu_resp_valid, bus.ifu_resp_data, timeout_err, spurious_err, busy);
    end
    idle_inputs();
  endtask

  task automatic test_timeout;
    logic early;
    early = 1'b0;
    next_cycle();
    bus.lsu_req_valid = 1'b1;
    bus.lsu_req_addr  = 32'h0000_0300;
    bus.lsu_req_wen   = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      next_cycle();
      bus.lsu_req_valid = 1'b0;
      bus.mem_req_ready = (c == 1);
      #1;
      if (bus.ifu_resp_valid || bus.lsu_resp_valid || timeout_err) early = 1'b1;
    end
    n_cmp++;
    if (early !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout_early: got early pulse/err=1 want 0");
    end
    next_cycle();
    #1;
    n_cmp++;
    if ({bus.lsu_resp_valid, bus.lsu_resp_data, bus.ifu_resp_valid, timeout_err, busy, bus.mem_req_valid, spurious_err} !==
        {1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL timeout_fire: got v=%b data=%h ifu_v=%b tmo=%b busy=%b mv=%b spur=%b want 1 deadbeef 0 1 0 0 0",
               bus.lsu_resp_valid, bus.lsu_resp_data, bus.ifu_resp_valid, timeout_err, busy, bus.mem_req_valid, spurious_err);
    end
    next_cycle();
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = 32'h5555_AAAA;
    next_cycle();
    bus.mem_resp_valid = 1'b0;
    #1;
    n_cmp++;
    if ({spurious_err, timeout_err, bus.lsu_resp_valid, bus.ifu_resp_valid, bus.lsu_resp_data} !==
        {1'b1, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF}) begin
      n_bad++;
      $display("FAIL timeout_late_resp: got spur=%b tmo=%b lsu_v=%b ifu_v=%b data=%h want 1 1 0 0 deadbeef",
               spurious_err, timeout_err, bus.lsu_resp_valid, bus.ifu_resp_valid, bus.lsu_resp_data);
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_wait;
    next_cycle();
    bus.lsu_req_valid = 1'b1;
    bus.lsu_req_addr  = 32'h0000_0400;
    bus.mem_req_ready = 1'b1;
    next_cycle();
    bus.lsu_req_valid = 1'b0;
    next_cycle();
    bus.mem_req_ready = 1'b0;
    #1;
    n_cmp++;
    if ({dbg_state, owner} !== {2'd2, 1'b1}) begin
      n_bad++;
      $display("FAIL rst_pre_wait: got state=%0d owner=%b want state=2 owner=1", dbg_state, owner);
    end
    rstn = 1'b0;
    bus.lsu_req_valid = 1'b1;
    #1;
    n_cmp++;
    if ({busy, owner, timeout_err, spurious_err, bus.mem_req_valid, bus.ifu_resp_valid, bus.lsu_resp_valid,
         bus.ifu_req_ready, bus.lsu_req_ready, bus.ifu_resp_data, bus.lsu_resp_data, bus.mem_req_addr} !== 105'd0) begin
      n_bad++;
      $display("FAIL rst_mid_wait: got busy=%b owner=%b tmo=%b spur=%b lsu_rdy=%b ifu_d=%h lsu_d=%h addr=%h want all 0",
               busy, owner, timeout_err, spurious_err, bus.lsu_req_ready, bus.ifu_resp_data, bus.lsu_resp_data, bus.mem_req_addr);
    end
    next_cycle();
    bus.lsu_req_valid = 1'b0;
    rstn = 1'b1;
    next_cycle();
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = 32'h7777_7777;
    next_cycle();
    bus.mem_resp_valid = 1'b0;
    #1;
    n_cmp++;
    if ({bus.ifu_resp_valid, bus.lsu_resp_valid, spurious_err, timeout_err, busy} !== {1'b0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL rst_stale_resp: got ifu_v=%b lsu_v=%b spur=%b tmo=%b busy=%b want 0 0 1 0 0",
               bus.ifu_resp_valid, bus.lsu_resp_valid, spurious_err, timeout_err, busy);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_ifu_read();
    test_starvation();
    test_store_stall();
    test_coincide();
    test_timeout();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the core's single memory port between the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read/write).
- Sits between the IFU/LSU and the memory model.
- One transaction is outstanding at a time.
- LSU has priority, with an IFU starvation guard and a response timeout watchdog.

Parameters:
- MAX_IFU_WAIT, 4: consecutive arbitration losses after which the IFU is forced to win (1..255).
- TIMEOUT, 255: cycles allowed in ISSUE+WAIT before the transaction is aborted (1..65535).

Ports:
- clk  in  1  clock, rising edge
- rstn  in  1  asynchronous active-low reset
- ifu_req_valid  in  1  IFU read request
- ifu_req_addr  in  32  IFU read address
- ifu_req_ready  out  1  IFU request accepted this cycle
- ifu_resp_valid  out  1  IFU response pulse
- ifu_resp_data  out  32  IFU read data
- lsu_req_valid  in  1  LSU request
- lsu_req_addr  in  32  LSU address
- lsu_req_wen  in  1  1 = store, 0 = load
- lsu_req_wdata  in  32  store data
- lsu_req_wmask  in  4  store byte strobes
- lsu_req_ready  out  1  LSU request accepted this cycle
- lsu_resp_valid  out  1  LSU response pulse (loads and stores)
- lsu_resp_data  out  32  load data (0 for stores)
- mem_req_valid  out  1  request to memory
- mem_req_addr  out  32  latched address
- mem_req_wen  out  1  latched write enable
- mem_req_wdata  out  32  latched write data
- mem_req_wmask  out  4  latched strobes (4'b0000 for reads)
- mem_req_ready  in  1  memory accepts request
- mem_resp_valid  in  1  memory response / write ack
- mem_resp_data  in  32  memory read data
- busy  out  1  state != IDLE
- owner  out  1  0 = IFU, 1 = LSU (current/last grant)
- timeout_err  out  1  sticky, set on any abort
- spurious_err  out  1  sticky, set on mem_resp_valid outside WAIT

Behaviour:
- Reset (async, rstn=0): state=IDLE; all outputs 0; wait_cnt=0; tmo_cnt=0; latched request registers 0. Reset mid-transaction abandons it silently: no response pulse; memory responses arriving after release are flagged spurious.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE arbitration:
  - winner = LSU if lsu_req_valid and not (ifu_req_valid and wait_cnt==MAX_IFU_WAIT); else IFU if ifu_req_valid.
  - *_req_ready is combinational: high only in IDLE, only for the winner.
  - On accept, latch addr/wen/wdata/wmask (IFU: wen=0, wmask=0, wdata=0), set owner, go to ISSUE.
- wait_cnt (8-bit):
  - +1 when in IDLE with both valid and LSU winning.
  - Cleared when the IFU is granted.
  - Saturates at MAX_IFU_WAIT.
  - Unchanged otherwise.
- ISSUE: mem_req_valid=1 with latched fields, held stable until mem_req_ready. On mem_req_ready, go to WAIT.
- WAIT: on mem_resp_valid, next cycle the owner's resp_valid=1 for exactly one cycle. resp_data = registered mem_resp_data, or 0 for a store. The FSM returns to IDLE in that same cycle, and a new accept is allowed in that same cycle.
- Minimum latency: accept at cycle N; mem_req_valid at N+1; response at N+2 if ready at N+1; resp_valid at N+3.
- tmo_cnt (16-bit):
  - Cleared on accept; increments each cycle in ISSUE or WAIT.
  - When it reaches TIMEOUT, go to IDLE, pulse the owner's resp_valid with data 32'hDEADBEEF, set timeout_err, drop mem_req_valid.
  - If mem_resp_valid and timeout coincide, the real response wins and there is no error.
- mem_resp_valid in IDLE or ISSUE is ignored and sets spurious_err.
- A response for the aborted transaction arriving later is flagged spurious.
- resp_data holds its value between pulses. The non-owner's resp_valid is always 0.
- Sticky errors clear only on reset.

Test Plan:
- IFU-only read, addr 0x8000_0000, memory ready immediately, response 0x0000_0413 next cycle -> ifu_req_ready at cycle 0, mem_req_valid at cycle 1, ifu_resp_valid=1/data=0x0000_0413 at cycle 3, busy low again at cycle 3.
- Both valid continuously, LSU loads back to back, MAX_IFU_WAIT=4 -> LSU granted 4 times, 5th grant to the IFU, wait_cnt back to 0, LSU granted next.
- LSU store addr 0x8000_0100, wdata 0xA5A5_A5A5, wmask 4'b0011, mem_req_ready low for 3 cycles -> mem_req_* fields stable throughout, lsu_resp_valid pulses with data 0 after the ack.
- Memory never responds, TIMEOUT=10 -> owner resp_valid with 0xDEADBEEF exactly 10 cycles after accept, timeout_err=1; a later mem_resp_valid sets spurious_err=1.
- rstn asserted in WAIT -> all outputs 0 immediately; after release the pending mem_resp_valid produces no resp pulse and sets spurious_err.
- mem_resp_valid on the same cycle the timeout would fire -> normal data returned, timeout_err stays 0.
